dmem_bus_if: RTL and testbench

- Data-side bus interface sitting directly downstream of the MEM stage.
- Converts the MEM stage's single-cycle combinational memory request into a registered req/ack bus transaction, e.g. a Wishbone-classic style slave.
- Returns load data to the MEM stage and raises a stall request to the pipeline controller until the access completes.
- Owns a watchdog that aborts hung accesses and flags a bus error to the exception logic.

---
 rtl/dmem_bus_if.sv | 139 +++++++++++++
 tb/tb_dmem_bus_if.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_if.sv
// rtl/dmem_bus_if.sv - MEM-stage to req/ack data bus bridge with stall generation and watchdog
module dmem_bus_if #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q;
    beat_t           beat_q;
    logic            cyc_q;
    logic            err_q;
    logic [31:0]     rd_buf_q;
    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    beat_t           beat_d;

    assign cnt_d  = cnt_q + TO_W'(1);
    assign beat_d = '{we: mem_we_i, adr: mem_addr_i, sel: mem_sel_i, dat: mem_data_i};

    // Flush dominates every state; bus fields are zeroed whenever the cycle ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            cyc_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_buf_q <= '0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (flush_i) begin
                state_q  <= S_IDLE;
                beat_q   <= '0;
                cyc_q    <= 1'b0;
                rd_buf_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (mem_ce_i) begin
                            beat_q  <= beat_d;
                            cyc_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (bus_ack_i) begin
                            beat_q   <= '0;
                            cyc_q    <= 1'b0;
                            rd_buf_q <= beat_q.we ? 32'h0 : bus_dat_i;
                            state_q  <= stall_i ? S_HOLD : S_IDLE;
                        end else if (cnt_q == CNT_LAST) begin
                            beat_q   <= '0;
                            cyc_q    <= 1'b0;
                            err_q    <= 1'b1;
                            rd_buf_q <= '0;
                            state_q  <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Ack cycle bypasses bus data straight to the MEM stage so it completes this cycle.
    always_comb begin
        stallreq_o = 1'b0;
        mem_data_o = '0;
        if (!rst && !flush_i) begin
            case (state_q)
                S_IDLE: stallreq_o = mem_ce_i;
                S_BUSY: begin
                    if (bus_ack_i) begin
                        mem_data_o = beat_q.we ? 32'h0 : bus_dat_i;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                S_HOLD: mem_data_o = rd_buf_q;
                default: begin
                    stallreq_o = 1'b0;
                    mem_data_o = '0;
                end
            endcase
        end
    end

    assign bus_cyc_o = cyc_q;
    assign bus_stb_o = cyc_q;
    assign bus_we_o  = beat_q.we;
    assign bus_adr_o = beat_q.adr;
    assign bus_sel_o = beat_q.sel;
    assign bus_dat_o = beat_q.dat;
    assign bus_err_o = err_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// tb/tb_dmem_bus_if.sv - scoreboard bench for dmem_bus_if with a reactive slave and pipeline model
module tb_dmem_bus_if;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_data;
    logic [3:0]  mem_sel;
    logic        stall_i, flush_i;
    logic        ext_stall, flush_drv;
    logic [31:0] mem_data_o;
    logic        stallreq_o, bus_err_o, bus_cyc_o, bus_stb_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack_i;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    int          slave_wait = 99;
    logic [31:0] slave_data = 32'h0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        int          stalls;
        int          stbs;
        logic [31:0] data;
        logic        err;
        int          hold;
    } done_t;

    beat_t exp_bus[$];
    done_t exp_done[$];

    // Controller folds stallreq into stall; exception logic flushes on a bus error.
    assign stall_i = stallreq_o | ext_stall;
    assign flush_i = flush_drv | bus_err_o;

    always #5 clk = ~clk;

    dmem_bus_if #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_sel_i(mem_sel), .mem_data_i(mem_data),
        .stall_i(stall_i), .flush_i(flush_i),
        .mem_data_o(mem_data_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
        .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
        .bus_adr_o(bus_adr_o), .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o),
        .bus_dat_i(bus_dat_i), .bus_ack_i(bus_ack_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave: acks after slave_wait strobe cycles, junk data otherwise, stray acks while idle.
    initial begin
        int scnt;
        scnt = 0;
        bus_ack_i = 1'b0;
        bus_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_stb_o) begin
                bus_ack_i = (scnt == slave_wait);
                bus_dat_i = bus_ack_i ? slave_data : $urandom();
                scnt++;
            end else begin
                scnt = 0;
                bus_ack_i = ($urandom_range(0, 3) == 0);
                bus_dat_i = $urandom();
            end
        end
    end

    // Monitor: checks each bus beat and each access completion against the queues.
    initial begin
        int          stall_cnt, stb_cnt, hold_left;
        logic [31:0] hold_data;
        bit          prev_stb, post_done;
        beat_t       b;
        done_t       d;
        stall_cnt = 0; stb_cnt = 0; hold_left = 0; hold_data = 0;
        prev_stb = 0; post_done = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("cyc_eq_stb", 32'(bus_cyc_o), 32'(bus_stb_o));
                if (post_done) begin
                    chk("cyc_drop", 32'(bus_stb_o), 0);
                    post_done = 0;
                end
                if (hold_left > 0) begin
                    chk("hold_stallreq", 32'(stallreq_o), 0);
                    chk("hold_data", mem_data_o, hold_data);
                    chk("hold_no_stb", 32'(bus_stb_o), 0);
                    hold_left--;
                end
                if (bus_stb_o && !prev_stb) begin
                    if (exp_bus.size() == 0) begin
                        chk("unexpected_stb", 32'(bus_stb_o), 0);
                    end else begin
                        b = exp_bus.pop_front();
                        chk("bus_we", 32'(bus_we_o), 32'(b.we));
                        chk("bus_adr", bus_adr_o, b.adr);
                        chk("bus_sel", 32'(bus_sel_o), 32'(b.sel));
                        chk("bus_dat", bus_dat_o, b.dat);
                    end
                end
                prev_stb = bus_stb_o;
                if (stallreq_o) stall_cnt++;
                if (bus_stb_o) stb_cnt++;
                if (stall_cnt > 0 && !stallreq_o) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'(stall_cnt), 0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(d.stalls));
                        chk("stb_cycles", 32'(stb_cnt), 32'(d.stbs));
                        chk("done_data", mem_data_o, d.data);
                        chk("done_err", 32'(bus_err_o), 32'(d.err));
                        hold_left = d.hold;
                        hold_data = d.data;
                    end
                    post_done = 1;
                    stall_cnt = 0;
                    stb_cnt = 0;
                end else begin
                    chk("no_err", 32'(bus_err_o), 0);
                end
            end
        end
    end

    // kind: 0 = acked after w waits, 1 = never acked, 2 = flushed in strobe cycle f (0 = issue cycle)
    task automatic txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wdat, input logic [31:0] rdat,
                       input int kind, input int w, input int f, input int s);
        beat_t b;
        done_t d;
        int    j;
        bit    done;
        int    sh;
        sh = (kind == 0) ? s : 0;
        b.we = we; b.adr = adr; b.sel = sel; b.dat = wdat;
        if (kind == 0) begin
            d.stalls = w + 1; d.stbs = w + 1; d.data = we ? 32'h0 : rdat; d.err = 0; d.hold = sh;
        end else if (kind == 1) begin
            d.stalls = TIMEOUT + 1; d.stbs = TIMEOUT; d.data = 32'h0; d.err = 1; d.hold = 0;
        end else begin
            d.stalls = f; d.stbs = f; d.data = 32'h0; d.err = 0; d.hold = 0;
        end
        if (!(kind == 2 && f == 0)) begin
            exp_bus.push_back(b);
            exp_done.push_back(d);
        end
        slave_wait = (kind == 1) ? 99 : w;
        slave_data = rdat;
        mem_ce = 1; mem_we = we; mem_addr = adr; mem_sel = sel; mem_data = wdat;
        ext_stall = (sh > 0);
        if (kind == 2 && f == 0) flush_drv = 1;
        j = 0;
        done = 0;
        while (!done && j < 40) begin
            @(negedge clk);
            if (!stallreq_o) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                j++;
                if (kind == 2 && j == f) flush_drv = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_complete: got no completion expected one within 40 cycles");
        end
        repeat (sh) @(posedge clk);
        #1 ext_stall = 0;
        @(posedge clk);
        #1;
        mem_ce = 0; flush_drv = 0; mem_we = 0;
        mem_addr = $urandom(); mem_sel = 4'($urandom()); mem_data = $urandom();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int kind, w, f, s, r;
        rst = 1; mem_ce = 1; mem_we = 1; mem_addr = 32'hA5A5_0010; mem_sel = 4'hC;
        mem_data = 32'h1357_9BDF; ext_stall = 0; flush_drv = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stallreq", 32'(stallreq_o), 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_cyc", 32'(bus_cyc_o), 0);
        chk("rst_adr", bus_adr_o, 0);
        chk("rst_err", 32'(bus_err_o), 0);
        @(posedge clk);
        #1 rst = 0;
        repeat (2) begin @(posedge clk); #1; end
        chk("pre_rst_busy_stb", 32'(bus_stb_o), 1);
        chk("pre_rst_busy_adr", bus_adr_o, 32'hA5A5_0010);
        rst = 1;
        @(negedge clk);
        chk("rst_busy_stallreq", 32'(stallreq_o), 0);
        chk("rst_busy_mem_data", mem_data_o, 0);
        @(posedge clk);
        #1 rst = 0; mem_ce = 0;
        @(negedge clk);
        chk("post_rst_cyc", 32'(bus_cyc_o), 0);
        chk("post_rst_stb", 32'(bus_stb_o), 0);
        chk("post_rst_we", 32'(bus_we_o), 0);
        chk("post_rst_adr", bus_adr_o, 0);
        chk("post_rst_sel", 32'(bus_sel_o), 0);
        chk("post_rst_dat", bus_dat_o, 0);
        chk("post_rst_stallreq", 32'(stallreq_o), 0);
        mon_en = 1;
        @(posedge clk);
        #1;

        txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        txn(1'b1, 32'h0000_0203, 4'h1, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 0, 3, 0, 0);
        txn(1'b0, 32'h0000_0080, 4'hF, 32'h0, 32'h1234_5678, 0, 1, 0, 3);
        txn(1'b0, 32'h0000_0300, 4'hF, 32'h0, 32'h0BAD_0BAD, 1, 0, 0, 0);
        txn(1'b0, 32'h0000_0400, 4'hF, 32'h0, 32'hCAFE_F00D, 2, 3, 2, 0);
        txn(1'b1, 32'h0000_0404, 4'h3, 32'h7777_7777, 32'h0, 2, 1, 2, 0);
        txn(1'b0, 32'h0000_0408, 4'hF, 32'h0, 32'h600D_D00D, 0, 0, 0, 0);
        txn(1'b0, 32'h0000_040C, 4'hF, 32'h0, 32'h1111_2222, 2, 2, 0, 0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            kind = (r < 60) ? 0 : (r < 75) ? 1 : 2;
            w = $urandom_range(0, 3);
            s = (kind == 0) ? $urandom_range(0, 3) : 0;
            f = (kind == 2) ? $urandom_range(0, w + 1) : 0;
            txn(1'($urandom()), $urandom(), 4'($urandom_range(1, 15)), $urandom(), $urandom(),
                kind, w, f, s);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("queues_drained", 32'(exp_done.size() + exp_bus.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
